// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//   Round-robin arbiter that shares one combinational ALU among N_REQ
//   requesters. One operation is in flight at a time:
//     IDLE : grant the first valid requester at or above rr_ptr (wrapping),
//            latch its operands on the accept edge.
//     EXEC : drive the shared ALU for one cycle, capture alu_y.
//     RESP : present the result until the consumer accepts it, then advance
//            rr_ptr past the served requester and bump op_count.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester handshake (ready is one-hot or zero)
//   req_a/b/op        packed per-requester operands and opcode
//   alu_en/a/b/op     shared ALU drive (operands zero while alu_en is low)
//   alu_y             shared ALU result, combinational from alu_a/b/op
//   rsp_valid/ready   result handshake, rsp_id/rsp_data carry the result
//   busy              high whenever the FSM is not IDLE
//   op_count          completed-operation counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*3-1:0]     req_op,
  output logic                   alu_en,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [2:0]             alu_op,
  input  logic [WIDTH-1:0]       alu_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [1:0]             rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy,
  output logic [15:0]            op_count
);

  localparam int ID_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_rr_ptr;
  logic [ID_W-1:0] r_id;
  logic [ID_W-1:0] r_rsp_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]      r_op;
  logic [WIDTH-1:0] r_rsp_data;
  logic [15:0]     r_op_count;

  logic [ID_W-1:0] w_scan;
  logic [ID_W-1:0] w_win_id;
  logic            w_win_found;
  logic            w_accept;
  logic            w_complete;

  // Walk the scan offsets from highest to lowest so the lowest offset from
  // rr_ptr that has a valid request is the one left standing. The 2-bit
  // sum wraps naturally because N_REQ is 4.
  always_comb begin
    w_scan      = '0;
    w_win_id    = r_rr_ptr;
    w_win_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_scan = r_rr_ptr + ID_W'(k);
      if (req_valid[w_scan]) begin
        w_win_found = 1'b1;
        w_win_id    = w_scan;
      end
    end
  end

  assign w_accept   = (r_state == S_IDLE) && w_win_found;
  assign w_complete = (r_state == S_RESP) && rsp_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_win_id] = 1'b1;
    alu_en    = (r_state == S_EXEC);
    alu_a     = alu_en ? r_a  : '0;
    alu_b     = alu_en ? r_b  : '0;
    alu_op    = alu_en ? r_op : 3'd0;
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
  end

  // Operand latch: only meaningful while EXEC, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a  <= req_a[int'(w_win_id)*WIDTH +: WIDTH];
      r_b  <= req_b[int'(w_win_id)*WIDTH +: WIDTH];
      r_op <= req_op[int'(w_win_id)*3 +: 3];
      r_id <= w_win_id;
    end
  end

  // Result capture at the end of EXEC; held until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
    end else if (r_state == S_EXEC) begin
      r_rsp_data <= alu_y;
      r_rsp_id   <= r_id;
    end
  end

  // Round-robin pointer and completion counter advance on response accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_op_count <= '0;
    end else if (w_complete) begin
      r_rr_ptr   <= r_rsp_id + 1'b1;
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign rsp_id   = r_rsp_id;
  assign rsp_data = r_rsp_data;
  assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_req_arbiter
//   Directed and randomized stimulus for alu_req_arbiter. The bench supplies
//   the shared ALU and keeps a small reference model (round-robin pointer and
//   completion count) from which every expected value is derived.
// -----------------------------------------------------------------------------
module tb_alu_req_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N*3-1:0] req_op = '0;
  logic           alu_en;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [2:0]     alu_op;
  logic [W-1:0]   alu_y;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           busy;
  logic [15:0]    op_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_ptr = 0;
  logic [15:0] m_cnt = '0;

  logic [W-1:0] ta  [N];
  logic [W-1:0] tb  [N];
  logic [2:0]   top [N];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  assign alu_y = ref_alu(alu_a, alu_b, alu_op);

  alu_req_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_en    (alu_en),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W]  = ta[i];
      req_b[i*W +: W]  = tb[i];
      req_op[i*3 +: 3] = top[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ta[i]  = $urandom;
      tb[i]  = $urandom;
      top[i] = 3'($urandom);
    end
  endtask

  // One full operation: grant, EXEC, RESP with `delay` stalled cycles.
  task automatic run_op(input logic [3:0] vld, input int delay, input bit early);
    int           w;
    bit           found;
    logic [W-1:0] ea, eb, ey;
    logic [2:0]   eo;
    w = 0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && vld[(m_ptr + k) % N]) begin
        found = 1'b1;
        w = (m_ptr + k) % N;
      end
    end
    ea = ta[w];
    eb = tb[w];
    eo = top[w];
    ey = ref_alu(ea, eb, eo);
    drive_ops();
    req_valid = vld;
    rsp_ready = early;
    #1;
    chk("grant", 64'(req_ready), 64'(1) << w);
    chk("idle_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("exec_en", 64'(alu_en), 64'd1);
    chk("exec_a", 64'(alu_a), 64'(ea));
    chk("exec_b", 64'(alu_b), 64'(eb));
    chk("exec_op", 64'(alu_op), 64'(eo));
    chk("exec_ready", 64'(req_ready), 64'd0);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("resp_valid", 64'(rsp_valid), 64'd1);
    chk("resp_id", 64'(rsp_id), 64'(w));
    chk("resp_data", 64'(rsp_data), 64'(ey));
    chk("resp_ready", 64'(req_ready), 64'd0);
    chk("resp_busy", 64'(busy), 64'd1);
    for (int i = 0; i < delay; i++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_id_data", {30'd0, rsp_id, rsp_data}, {30'd0, 2'(w), ey});
      chk("hold_ready", 64'(req_ready), 64'd0);
      chk("hold_busy", 64'(busy), 64'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    m_ptr = (w + 1) % N;
    m_cnt = m_cnt + 16'd1;
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_valid", 64'(rsp_valid), 64'd0);
    chk("op_count", 64'(op_count), 64'(m_cnt));
    chk("retain_data", 64'(rsp_data), 64'(ey));
    chk("retain_id", 64'(rsp_id), 64'(w));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(op_count), 64'd0);
    chk("rst_alu", {31'd0, alu_en, alu_a}, 64'd0);
    chk("rst_rsp", {30'd0, rsp_id, rsp_data}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_cnt = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      ta[i] = '0; tb[i] = '0; top[i] = '0;
    end

    // Reset state
    do_reset();
    chk("idle_ready", 64'(req_ready), 64'd0);

    // Single request on requester 1: 5 + 3
    rand_ops();
    ta[1] = 32'h5; tb[1] = 32'h3; top[1] = 3'd0;
    run_op(4'b0010, 0, 1'b0);
    chk("single_sum", 64'(rsp_data), 64'h8);

    // Round-robin with all requesters held: order 0,1,2,3,0
    do_reset();
    for (int n = 0; n < 5; n++) begin
      rand_ops();
      run_op(4'b1111, 0, 1'b1);
      chk("rr_order", 64'(rsp_id), 64'(n % N));
    end
    chk("rr_count", 64'(op_count), 64'd5);

    // Backpressure: ten stalled cycles in RESP
    rand_ops();
    run_op(4'b0100, 10, 1'b0);

    // Gating while idle with all-ones operands
    for (int i = 0; i < N; i++) begin
      ta[i] = '1; tb[i] = '1; top[i] = 3'd7;
    end
    drive_ops();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("gate_en", 64'(alu_en), 64'd0);
      chk("gate_ab", {alu_a, alu_b}, 64'd0);
      chk("gate_op", 64'(alu_op), 64'd0);
      chk("gate_ready", 64'(req_ready), 64'd0);
    end

    // Asynchronous reset while in EXEC
    rand_ops();
    drive_ops();
    req_valid = 4'b1000;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(rsp_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_count", 64'(op_count), 64'd0);
    chk("arst_alu", {31'd0, alu_en, alu_a}, 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_cnt = '0;
    @(posedge clk); #1;
    chk("arst_no_rsp", {62'd0, rsp_valid, busy}, 64'd0);
    rand_ops();
    run_op(4'b1111, 0, 1'b0);
    chk("arst_first_id", 64'(rsp_id), 64'd0);

    // Randomized operations with idle gaps and random stalls
    for (int n = 0; n < 30; n++) begin
      int gap;
      bit early;
      gap = $urandom_range(0, 2);
      for (int c = 0; c < gap; c++) begin
        @(posedge clk); #1;
        chk("gap_ready", 64'(req_ready), 64'd0);
        chk("gap_en", 64'(alu_en), 64'd0);
      end
      rand_ops();
      early = ($urandom_range(0, 3) == 0);
      run_op(4'($urandom_range(1, 15)), early ? 0 : $urandom_range(0, 3), early);
    end

    // Counter wrap from 16'hFFFF
    force dut.r_op_count = 16'hFFFF;
    #1;
    release dut.r_op_count;
    chk("wrap_preload", 64'(op_count), 64'hFFFF);
    m_cnt = 16'hFFFF;
    rand_ops();
    run_op(4'b0001, 1, 1'b0);
    chk("wrap_zero", 64'(op_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 Parameter: N_REQ, 4, requester count (fixed at 4 for this revision; id width 2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  N_REQ  per-requester operation request.
REQ-006 req_ready  out  N_REQ  per-requester accept; at most one bit high.
REQ-007 req_a  in  N_REQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 req_b  in  N_REQ*WIDTH  operand B; same packing.
REQ-009 req_op  in  N_REQ*3  opcode; requester i at bits [i*3 +: 3].
REQ-010 alu_en  out  1  shared-ALU enable/gate.
REQ-011 alu_a, alu_b  out  WIDTH  shared-ALU operands.
REQ-012 alu_op  out  3  shared-ALU opcode.
REQ-013 alu_y  in  WIDTH  shared-ALU result, combinational from alu_a/alu_b/alu_op.
REQ-014 rsp_valid  out  1  result available.
REQ-015 rsp_ready  in  1  result consumer accept.
REQ-016 rsp_id  out  2  index of requester owning result.
REQ-017 rsp_data  out  WIDTH  result.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 op_count  out  16  completed-operation counter.

Function
REQ-020 FSM states IDLE, EXEC, RESP; registered state.
REQ-021 IDLE: if any req_valid, winner = first set req_valid scanning upward (mod N_REQ) from rr_ptr; req_ready[winner]=1 combinationally, all other ready bits 0.
REQ-022 IDLE with no req_valid: all req_ready 0, stay IDLE.
REQ-023 Transfer occurs on the edge where req_valid[w] & req_ready[w]; latch req_a/req_b/req_op slice of w and id w; go to EXEC.
REQ-024 req_ready SHALL be 0 in EXEC and RESP; requests held meanwhile are not dropped, just not accepted.
REQ-025 EXEC lasts exactly one cycle: alu_en=1, alu_a/alu_b/alu_op = latched values; at end of cycle capture alu_y into rsp_data; go to RESP.
REQ-026 When alu_en=0, alu_a, alu_b, alu_op SHALL be all zeros.
REQ-027 RESP: rsp_valid=1, rsp_id/rsp_data stable until rsp_valid & rsp_ready edge; then go to IDLE, rr_ptr = (id+1) mod N_REQ, op_count increments.
REQ-028 rsp_ready high before RESP has no effect.
REQ-029 Latency: accept edge at cycle 0 -> alu_en cycle 1 -> rsp_valid cycle 2; minimum 3 cycles per operation.
REQ-030 Round-robin fairness: a continuously requesting requester is served within N_REQ operations.
REQ-031 op_count wraps 16'hFFFF -> 16'h0000 without side effects.
REQ-032 rsp_data/rsp_id retain last values after response until next EXEC capture.

Reset
REQ-033 rst high SHALL immediately force state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0, busy=0, alu_en=0, alu operands 0, independent of clk.
REQ-034 rst during EXEC or RESP discards the in-flight operation; no response issued, op_count unchanged from 0.
REQ-035 First arbitration after reset starts scanning at requester 0.

Verification
REQ-036 Single request: req_valid=4'b0010, a=32'h00000005, b=32'h00000003, op=3'd0 -> req_ready=4'b0010 cycle 0, alu_en=1 with alu_a=5, alu_b=3 cycle 1, rsp_valid=1, rsp_id=1, rsp_data=bench ALU result cycle 2.
REQ-037 Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; op_count=5 after five responses.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable, req_ready=0, busy=1 throughout; completion one edge after rsp_ready=1.
REQ-039 Gating: idle with a=32'hFFFFFFFF on all requesters, req_valid=0 -> alu_en=0, alu_a=alu_b=32'h00000000.
REQ-040 Async reset in EXEC: assert rst between clock edges -> rsp_valid=0, busy=0, op_count=0 before next edge; next request served from requester 0 scan.
REQ-041 Counter wrap: preload via 65536 completions (or force) -> op_count rolls from 16'hFFFF to 16'h0000.
